// File: rtl/femtorv_nmi_bridge_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | femtorv_nmi_bridge_if : nmi valid/ready request bus between bridge/slave |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface femtorv_nmi_bridge_if;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface
`default_nettype wire

// File: rtl/femtorv_nmi_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | femtorv_nmi_bridge : FemtoRV32 strobe/busy port to nmi valid/ready bus   |
// |                      with bus watchdog and sticky error capture          |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module femtorv_nmi_bridge #(
  parameter int unsigned TIMEOUT  = 1024,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [31:0]                 core_addr_i,
  input  logic [31:0]                 core_wdata_i,
  input  logic [3:0]                  core_wmask_i,
  input  logic                        core_rstrb_i,
  output logic [31:0]                 core_rdata_o,
  output logic                        core_rbusy_o,
  output logic                        core_wbusy_o,
  femtorv_nmi_bridge_if.master        nmi,
  input  logic                        err_clr_i,
  output logic                        err_o,
  output logic [31:0]                 err_addr_o
);

  localparam int unsigned      CNT_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam bit               WDOG_EN  = (TIMEOUT != 0);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic             rbusy_q, rbusy_d;
  logic             wbusy_q, wbusy_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [31:0]      eaddr_q, eaddr_d;

  logic             w_abort;
  logic             w_unused_addr_lsb;

  // The bus is word addressed; byte lanes are selected by the strobes.
  assign w_unused_addr_lsb = ^core_addr_i[1:0];
  assign w_abort           = WDOG_EN && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rbusy_d = rbusy_q;
    wbusy_d = wbusy_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    eaddr_d = eaddr_q;

    if (err_clr_i) begin
      err_d = 1'b0;
    end

    if (state_q == S_IDLE) begin
      if (|core_wmask_i) begin
        addr_d  = {core_addr_i[31:2], 2'b00};
        wdata_d = core_wdata_i;
        wstrb_d = core_wmask_i;
        wbusy_d = 1'b1;
        cnt_d   = '0;
        state_d = S_REQ;
      end else if (core_rstrb_i) begin
        addr_d  = {core_addr_i[31:2], 2'b00};
        wstrb_d = 4'h0;
        rbusy_d = 1'b1;
        cnt_d   = '0;
        state_d = S_REQ;
      end
    end else begin
      // Ready takes precedence over the watchdog on the same cycle.
      if (nmi.ready) begin
        rbusy_d = 1'b0;
        wbusy_d = 1'b0;
        state_d = S_IDLE;
        if (rbusy_q) begin
          rdata_d = nmi.rdata;
        end
      end else if (w_abort) begin
        rbusy_d = 1'b0;
        wbusy_d = 1'b0;
        state_d = S_IDLE;
        if (rbusy_q) begin
          rdata_d = ERR_DATA;
        end
        // A clear arriving with a fresh timeout still reports the new address.
        if (!err_q || err_clr_i) begin
          eaddr_d = addr_q;
        end
        err_d = 1'b1;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rbusy_q <= 1'b0;
      wbusy_q <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      eaddr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rbusy_q <= rbusy_d;
      wbusy_q <= wbusy_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      eaddr_q <= eaddr_d;
    end
  end

  assign nmi.valid    = (state_q == S_REQ);
  assign nmi.addr     = addr_q;
  assign nmi.wdata    = wdata_q;
  assign nmi.wstrb    = wstrb_q;
  assign core_rdata_o = rdata_q;
  assign core_rbusy_o = rbusy_q;
  assign core_wbusy_o = wbusy_q;
  assign err_o        = err_q;
  assign err_addr_o   = eaddr_q;

endmodule
`default_nettype wire

// File: tb/tb_femtorv_nmi_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_femtorv_nmi_bridge : directed table plus random transactions          |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_femtorv_nmi_bridge;
  localparam int unsigned TO   = 8;
  localparam logic [31:0] ERRW = 32'hDEAD_BEEF;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wdata_i;
  logic [3:0]  core_wmask_i;
  logic        core_rstrb_i;
  logic [31:0] core_rdata_o;
  logic        core_rbusy_o;
  logic        core_wbusy_o;
  logic        err_clr_i;
  logic        err_o;
  logic [31:0] err_addr_o;

  femtorv_nmi_bridge_if nmi_if ();

  femtorv_nmi_bridge #(.TIMEOUT(TO), .ERR_DATA(ERRW)) u_dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .core_addr_i  (core_addr_i),
    .core_wdata_i (core_wdata_i),
    .core_wmask_i (core_wmask_i),
    .core_rstrb_i (core_rstrb_i),
    .core_rdata_o (core_rdata_o),
    .core_rbusy_o (core_rbusy_o),
    .core_wbusy_o (core_wbusy_o),
    .nmi          (nmi_if),
    .err_clr_i    (err_clr_i),
    .err_o        (err_o),
    .err_addr_o   (err_addr_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          wr;
    bit          dual;
    bit          req_strb;
    bit          clr_first;
    bit          clr_abort;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          waits;
    logic [31:0] srd;
    logic [31:0] e_rdata;
    bit          e_err;
    logic [31:0] e_eaddr;
  } txn_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_rdata;
  bit          m_err;
  logic [31:0] m_eaddr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level reference: timeout iff the slave would wait TO or more cycles.
  task automatic model_predict(inout txn_t t);
    bit to;
    to = (t.waits >= int'(TO));
    if (t.clr_first) m_err = 1'b0;
    if (!t.wr) m_rdata = to ? ERRW : t.srd;
    if (to) begin
      if (!m_err || t.clr_abort) m_eaddr = t.addr & ~32'h3;
      m_err = 1'b1;
    end else if (t.clr_abort) begin
      m_err = 1'b0;
    end
    t.e_rdata = m_rdata;
    t.e_err   = m_err;
    t.e_eaddr = m_eaddr;
  endtask

  // Entered and left at a negedge; inputs set here are sampled on the next posedge.
  task automatic run_txn(input txn_t t);
    int h;
    if (t.clr_first) begin
      err_clr_i = 1'b1;
      @(negedge clk_i);
      err_clr_i = 1'b0;
      chk("err_clr", err_o, 0);
    end
    core_addr_i  = t.addr;
    core_wdata_i = t.wdata;
    core_wmask_i = t.wr ? t.wmask : 4'h0;
    core_rstrb_i = !t.wr || t.dual;
    @(negedge clk_i);
    core_rstrb_i = 1'b0;
    core_wmask_i = 4'h0;
    core_addr_i  = $urandom;
    core_wdata_i = $urandom;
    h = (t.waits < int'(TO)) ? t.waits + 1 : int'(TO);
    for (int k = 0; k < h; k++) begin
      chk("req_valid", nmi_if.valid, 1);
      chk("req_addr", nmi_if.addr, t.addr & ~32'h3);
      chk("req_wstrb", nmi_if.wstrb, t.wr ? t.wmask : 4'h0);
      if (t.wr) chk("req_wdata", nmi_if.wdata, t.wdata);
      chk("req_rbusy", core_rbusy_o, !t.wr);
      chk("req_wbusy", core_wbusy_o, t.wr);
      nmi_if.ready = (k == t.waits);
      nmi_if.rdata = (k == t.waits) ? t.srd : $urandom;
      if (t.req_strb && k == 0) core_rstrb_i = 1'b1;
      err_clr_i = t.clr_abort && (k == h - 1);
      @(negedge clk_i);
      nmi_if.ready = 1'b0;
      core_rstrb_i = 1'b0;
      err_clr_i    = 1'b0;
    end
    chk("done_valid", nmi_if.valid, 0);
    chk("done_rbusy", core_rbusy_o, 0);
    chk("done_wbusy", core_wbusy_o, 0);
    chk("done_rdata", core_rdata_o, t.e_rdata);
    chk("done_err", err_o, t.e_err);
    chk("done_eaddr", err_addr_o, t.e_eaddr);
    if (t.req_strb) begin
      @(negedge clk_i);
      chk("ignored_strobe", nmi_if.valid, 0);
    end
  endtask

  txn_t tbl[9];
  txn_t rt;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    tbl[0] = '{0,0,0,0,0,32'h0000_1004,32'h0,4'h0,0,32'h1234_5678,32'h1234_5678,0,32'h0};
    tbl[1] = '{1,0,0,0,0,32'h0000_2000,32'hAABB_CCDD,4'b0011,3,32'h0,32'h1234_5678,0,32'h0};
    tbl[2] = '{0,0,0,0,0,32'h0000_3000,32'h0,4'h0,20,32'h1111_1111,ERRW,1,32'h3000};
    tbl[3] = '{0,0,0,0,0,32'h0000_4002,32'h0,4'h0,20,32'h2222_2222,ERRW,1,32'h3000};
    tbl[4] = '{0,0,0,1,0,32'h0000_5000,32'h0,4'h0,7,32'h0BAD_F00D,32'h0BAD_F00D,0,32'h3000};
    tbl[5] = '{1,1,0,0,0,32'h0000_6000,32'h1122_3344,4'hF,1,32'h0,32'h0BAD_F00D,0,32'h3000};
    tbl[6] = '{0,0,1,0,0,32'h0000_7000,32'h0,4'h0,2,32'h55AA_55AA,32'h55AA_55AA,0,32'h3000};
    tbl[7] = '{1,0,0,0,0,32'h0000_8000,32'hCAFE_0001,4'b1000,20,32'h0,32'h55AA_55AA,1,32'h8000};
    tbl[8] = '{0,0,0,0,1,32'h0000_9000,32'h0,4'h0,20,32'h0,ERRW,1,32'h9000};

    rst_i        = 1'b1;
    core_addr_i  = 32'h0;
    core_wdata_i = 32'h0;
    core_wmask_i = 4'h0;
    core_rstrb_i = 1'b0;
    err_clr_i    = 1'b0;
    nmi_if.ready = 1'b0;
    nmi_if.rdata = 32'h0;
    repeat (2) @(negedge clk_i);
    chk("rst_valid", nmi_if.valid, 0);
    chk("rst_addr", nmi_if.addr, 0);
    chk("rst_wdata", nmi_if.wdata, 0);
    chk("rst_wstrb", nmi_if.wstrb, 0);
    chk("rst_rdata", core_rdata_o, 0);
    chk("rst_rbusy", core_rbusy_o, 0);
    chk("rst_wbusy", core_wbusy_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_eaddr", err_addr_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    for (int i = 0; i < 9; i++) run_txn(tbl[i]);

    // Reset while a read waits on the bus discards the transfer and the error state.
    core_addr_i  = 32'h0000_A000;
    core_rstrb_i = 1'b1;
    @(negedge clk_i);
    core_rstrb_i = 1'b0;
    chk("midrst_pre_valid", nmi_if.valid, 1);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("midrst_valid", nmi_if.valid, 0);
    chk("midrst_rbusy", core_rbusy_o, 0);
    chk("midrst_wbusy", core_wbusy_o, 0);
    chk("midrst_rdata", core_rdata_o, 0);
    chk("midrst_err", err_o, 0);
    chk("midrst_eaddr", err_addr_o, 0);
    @(negedge clk_i);
    chk("midrst_idle", nmi_if.valid, 0);

    m_rdata = 32'h0;
    m_err   = 1'b0;
    m_eaddr = 32'h0;
    for (int n = 0; n < 80; n++) begin
      rt.wr        = ($urandom_range(0, 1) == 1);
      rt.dual      = rt.wr && ($urandom_range(0, 3) == 0);
      rt.req_strb  = ($urandom_range(0, 3) == 0);
      rt.clr_first = ($urandom_range(0, 5) == 0);
      rt.clr_abort = ($urandom_range(0, 5) == 0);
      rt.addr      = $urandom;
      rt.wdata     = $urandom;
      rt.wmask     = rt.wr ? 4'($urandom_range(1, 15)) : 4'h0;
      rt.waits     = int'($urandom_range(0, 11));
      rt.srd       = $urandom;
      model_predict(rt);
      run_txn(rt);
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
